// File: rtl/mem_arbiter.sv
// Round-robin arbiter between two requesters in front of the shared Memory port.
// Hides the one-cycle read latency and VRAM busy stalls behind a req/ack handshake.
module mem_arbiter #(
   parameter logic [15:0] SCREEN_BASE = 16'h4000,
   parameter logic [15:0] KBD_BASE    = 16'h6000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        a_req_i,
   input  logic        a_we_i,
   input  logic [15:0] a_addr_i,
   input  logic [15:0] a_wdata_i,
   input  logic        b_req_i,
   input  logic        b_we_i,
   input  logic [15:0] b_addr_i,
   input  logic [15:0] b_wdata_i,
   output logic        a_ack_o,
   output logic [15:0] a_rdata_o,
   output logic        b_ack_o,
   output logic [15:0] b_rdata_o,
   output logic        grant_a_o,
   output logic        grant_b_o,
   output logic        mem_load_o,
   output logic [15:0] mem_address_o,
   output logic [15:0] mem_in_o,
   input  logic [15:0] mem_out_i,
   input  logic        mem_busy_i
);

   // state   | meaning
   // IDLE    | pick a winner among eligible requesters, latch its command
   // ISSUE   | drive the memory port; hold here while VRAM reports busy
   // WAIT_RD | memory output valid this cycle, capture into winner's rdata
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT_RD = 2'd2;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   logic [1:0]  state_q, state_d;
   logic        last_q, last_d;
   logic        cur_port_q, cur_port_d;
   logic        cur_we_q, cur_we_d;
   logic [15:0] cur_addr_q, cur_addr_d;
   logic [15:0] cur_wdata_q, cur_wdata_d;
   logic        a_ack_q, a_ack_d;
   logic        b_ack_q, b_ack_d;
   logic [15:0] a_rdata_q, a_rdata_d;
   logic [15:0] b_rdata_q, b_rdata_d;

   logic elig_a;
   logic elig_b;
   logic pick_b;
   logic vram_hit;
   logic kbd_hit;
   logic stall;

   // A port whose ack is high is still dropping req and must not be re-serviced.
   assign elig_a = a_req_i & ~a_ack_q;
   assign elig_b = b_req_i & ~b_ack_q;
   assign pick_b = elig_b & (~elig_a | (last_q == PORT_A));

   assign vram_hit = (cur_addr_q >= SCREEN_BASE) && (cur_addr_q < KBD_BASE);
   assign kbd_hit  = (cur_addr_q >= KBD_BASE);
   assign stall    = (state_q == ISSUE) && vram_hit && mem_busy_i;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cur_port_d  = cur_port_q;
      cur_we_d    = cur_we_q;
      cur_addr_d  = cur_addr_q;
      cur_wdata_d = cur_wdata_q;
      a_ack_d     = 1'b0;
      b_ack_d     = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;

      case (state_q)
         IDLE: begin
            if (elig_a || elig_b) begin
               state_d    = ISSUE;
               cur_port_d = pick_b;
               last_d     = pick_b;
               if (pick_b) begin
                  cur_we_d    = b_we_i;
                  cur_addr_d  = b_addr_i;
                  cur_wdata_d = b_wdata_i;
               end else begin
                  cur_we_d    = a_we_i;
                  cur_addr_d  = a_addr_i;
                  cur_wdata_d = a_wdata_i;
               end
            end
         end
         ISSUE: begin
            if (!stall) begin
               if (cur_we_q) begin
                  state_d = IDLE;
                  if (cur_port_q == PORT_B) b_ack_d = 1'b1;
                  else                      a_ack_d = 1'b1;
               end else begin
                  state_d = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            state_d = IDLE;
            if (cur_port_q == PORT_B) begin
               b_rdata_d = mem_out_i;
               b_ack_d   = 1'b1;
            end else begin
               a_rdata_d = mem_out_i;
               a_ack_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         last_q      <= PORT_B;
         cur_port_q  <= PORT_A;
         cur_we_q    <= 1'b0;
         cur_addr_q  <= 16'h0000;
         cur_wdata_q <= 16'h0000;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         a_rdata_q   <= 16'h0000;
         b_rdata_q   <= 16'h0000;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cur_port_q  <= cur_port_d;
         cur_we_q    <= cur_we_d;
         cur_addr_q  <= cur_addr_d;
         cur_wdata_q <= cur_wdata_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
      end
   end

   // cur_* only changes when leaving IDLE, so it also serves as the held value in IDLE.
   assign mem_address_o = cur_addr_q;
   assign mem_in_o      = cur_wdata_q;
   assign mem_load_o    = (state_q == ISSUE) && cur_we_q && !stall && !kbd_hit;

   assign grant_a_o = (state_q != IDLE) && (cur_port_q == PORT_A);
   assign grant_b_o = (state_q != IDLE) && (cur_port_q == PORT_B);
   assign a_ack_o   = a_ack_q;
   assign b_ack_o   = b_ack_q;
   assign a_rdata_o = a_rdata_q;
   assign b_rdata_o = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed spec scenarios plus random single-port traffic
// checked against a transaction-level memory/latency model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_req, a_we, b_req, b_we;
   logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_ack, b_ack, grant_a, grant_b, mem_load, mem_busy;
   logic [15:0] a_rdata, b_rdata, mem_address, mem_in, mem_out;

   int total = 0;
   int bad   = 0;

   bit          last_served;
   logic [15:0] exp_rd_a, exp_rd_b, kbd_val;
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] emu_mem [logic [15:0]];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .a_ack_o(a_ack), .a_rdata_o(a_rdata), .b_ack_o(b_ack), .b_rdata_o(b_rdata),
      .grant_a_o(grant_a), .grant_b_o(grant_b),
      .mem_load_o(mem_load), .mem_address_o(mem_address), .mem_in_o(mem_in),
      .mem_out_i(mem_out), .mem_busy_i(mem_busy)
   );

   // Hack Memory stand-in: one-cycle read latency, keyboard window returns kbd_val.
   always @(posedge clk) begin
      if (mem_address >= 16'h6000)          mem_out <= kbd_val;
      else if (emu_mem.exists(mem_address)) mem_out <= emu_mem[mem_address];
      else                                  mem_out <= 16'h0000;
      if (mem_load) emu_mem[mem_address] = mem_in;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_read(input logic [15:0] addr);
      if (addr >= 16'h6000)      return kbd_val;
      if (ref_mem.exists(addr))  return ref_mem[addr];
      return 16'h0000;
   endfunction

   task automatic drive(input bit p, input logic r, input logic w,
                        input logic [15:0] ad, input logic [15:0] wd);
      if (!p) begin a_req = r; a_we = w; a_addr = ad; a_wdata = wd; end
      else    begin b_req = r; b_we = w; b_addr = ad; b_wdata = wd; end
   endtask

   // Single-port transaction; busy is held high for the first k cycles after req is sampled.
   task automatic txn(input bit p, input bit we, input logic [15:0] addr,
                      input logic [15:0] wdata, input int k);
      int  lat, loads, load_cyc, exp_lat;
      bit  vram, done, ack, gp, go;
      logic [15:0] exp_rd;
      vram    = (addr >= 16'h4000) && (addr < 16'h6000);
      exp_lat = (we ? 2 : 3) + (vram ? k : 0);
      exp_rd  = ref_read(addr);
      @(negedge clk);
      drive(p, 1'b1, we, addr, wdata);
      mem_busy = (k > 0);
      lat = 0; loads = 0; load_cyc = 0; done = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         mem_busy = (lat <= k);
         @(negedge clk);
         ack = p ? b_ack : a_ack;
         gp  = p ? grant_b : grant_a;
         go  = p ? grant_a : grant_b;
         if (mem_load) begin
            loads++;
            load_cyc = lat;
            chk("load_addr", 32'(mem_address), 32'(addr));
            chk("load_data", 32'(mem_in), 32'(wdata));
         end
         chk("other_ack", 32'(p ? a_ack : b_ack), 0);
         if (ack) done = 1;
         else chk("grant_inflight", {30'd0, gp, go}, 32'b10);
      end
      mem_busy = 1'b0;
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("grants_at_ack", {30'd0, grant_a, grant_b}, 0);
      chk("load_count", 32'(loads), (we && addr < 16'h6000) ? 1 : 0);
      if (we && addr < 16'h6000) chk("load_cycle", 32'(load_cyc), 32'(exp_lat - 1));
      if (!we) begin
         if (p) exp_rd_b = exp_rd;
         else   exp_rd_a = exp_rd;
      end else if (addr < 16'h6000) begin
         ref_mem[addr] = wdata;
      end
      chk("a_rdata", 32'(a_rdata), 32'(exp_rd_a));
      chk("b_rdata", 32'(b_rdata), 32'(exp_rd_b));
      last_served = p;
      drive(p, 1'b0, 1'b0, addr, wdata);
   endtask

   // Both ports request together and keep req high for n writes each.
   task automatic contention(input int n);
      int  na, nb, cyc, viol, loads;
      bit  first, pga, pgb;
      bit  order[$];
      logic [15:0] da, db;
      na = 0; nb = 0; cyc = 0; viol = 0; loads = 0; pga = 0; pgb = 0;
      first = (last_served == 1'b1) ? 1'b0 : 1'b1;
      @(negedge clk);
      mem_busy = 1'b0;
      da = 16'($urandom); db = 16'($urandom);
      drive(1'b0, 1'b1, 1'b1, 16'h0100, da);
      drive(1'b1, 1'b1, 1'b1, 16'h0200, db);
      while ((na < n || nb < n) && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (grant_a && !pga) order.push_back(1'b0);
         if (grant_b && !pgb) order.push_back(1'b1);
         pga = grant_a; pgb = grant_b;
         if ((grant_a && a_ack) || (grant_b && b_ack)) viol++;
         if (mem_load) loads++;
         if (a_ack) begin
            ref_mem[16'h0100 + 16'(na)] = da;
            na++;
            da = 16'($urandom);
            drive(1'b0, na < n, 1'b1, 16'h0100 + 16'(na), da);
         end
         if (b_ack) begin
            ref_mem[16'h0200 + 16'(nb)] = db;
            nb++;
            db = 16'($urandom);
            drive(1'b1, nb < n, 1'b1, 16'h0200 + 16'(nb), db);
         end
      end
      chk("cont_cycles", 32'(cyc), 32'(4 * n));
      chk("cont_grants", 32'(order.size()), 32'(2 * n));
      for (int i = 0; i < order.size() && i < 2 * n; i++)
         chk($sformatf("cont_order%0d", i), {31'd0, order[i]}, {31'd0, first ^ i[0]});
      chk("cont_grant_vs_ack", 32'(viol), 0);
      chk("cont_loads", 32'(loads), 32'(2 * n));
      last_served = ~first;
   endtask

   initial begin
      bit seen;
      logic [15:0] ad;
      int r;
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      mem_busy = 0; kbd_val = 16'h0000;
      exp_rd_a = 0; exp_rd_b = 0; last_served = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctl", {27'd0, a_ack, b_ack, grant_a, grant_b, mem_load}, 0);
      chk("reset_data", {a_rdata, b_rdata}, 0);
      chk("reset_mem", {mem_address, mem_in}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {27'd0, a_ack, b_ack, grant_a, grant_b, mem_load}, 0);

      txn(1'b0, 1'b1, 16'h0010, 16'h1234, 0);
      txn(1'b0, 1'b0, 16'h0010, 16'h0000, 0);
      chk("readback_1234", 32'(a_rdata), 32'h1234);

      contention(4);

      txn(1'b1, 1'b1, 16'h4000, 16'hFFFF, 5);

      txn(1'b0, 1'b1, 16'h6000, 16'hAAAA, 0);
      kbd_val = 16'h0041;
      txn(1'b0, 1'b0, 16'h6000, 16'h0000, 0);
      chk("kbd_read", 32'(a_rdata), 32'h0041);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 5)      ad = 16'($urandom_range(0, 15));
         else if (r < 8) ad = 16'h4000 + 16'($urandom_range(0, 7));
         else begin
            case ($urandom_range(0, 4))
               0:       ad = 16'h3FFF;
               1:       ad = 16'h5FFF;
               2:       ad = 16'h6000;
               3:       ad = 16'hFFFF;
               default: ad = 16'h4000;
            endcase
         end
         kbd_val = 16'($urandom);
         txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ad,
             16'($urandom), $urandom_range(0, 3));
      end

      // Reset while B's read sits in WAIT_RD.
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrd_inflight", {30'd0, grant_b, mem_load}, 32'b10);
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
      #1;
      chk("midrd_ack", {30'd0, a_ack, b_ack}, 0);
      chk("midrd_b_rdata", 32'(b_rdata), 0);
      chk("midrd_grant", {30'd0, grant_a, grant_b}, 0);
      exp_rd_a = 0; exp_rd_b = 0; last_served = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (a_ack || b_ack) seen = 1;
      end
      chk("midrd_no_ack", {31'd0, seen}, 0);

      contention(1);
      txn(1'b1, 1'b0, 16'h0010, 16'h0000, 0);
      chk("post_reset_read", 32'(b_rdata), 32'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
